// File: rtl/alu_pkg.sv
// Shared types and helpers for the multicycle ALU: op encoding, FSM states
// and iterative-op classification.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MULU = 4'b1100,
        OP_DIVU = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the control FSM (master) and the ALU (slave).
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, result_hi, zero, negative, carry, overflow,
               div_by_zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, result_hi, zero, negative, carry, overflow,
               div_by_zero, busy, done
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring divide,
// one bit per step. nxt_*_c expose the post-step values so the final step can
// be written straight to the output registers.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt_lo_c,
    output logic [WIDTH-1:0] nxt_hi_c
);
    logic [WIDTH-1:0] acc_q;   // product high half / partial remainder
    logic [WIDTH-1:0] sh_q;    // multiplier / quotient shift register
    logic [WIDTH-1:0] opnd_q;  // multiplicand / divisor
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH:0]   sum;

    // Divide subtracts from the shifted remainder; its sign bit is the borrow.
    always_comb begin
        x = div ? {acc_q, sh_q[WIDTH-1]} : {1'b0, acc_q};
        y = {1'b0, opnd_q};
        if (div) begin
            sum = x - y;
        end else if (sh_q[0]) begin
            sum = x + y;
        end else begin
            sum = x;
        end
        if (div) begin
            nxt_hi_c = sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0];
            nxt_lo_c = {sh_q[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
            nxt_hi_c = sum[WIDTH:1];
            nxt_lo_c = {sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= '0;
            sh_q   <= div ? a : b;
            opnd_q <= div ? b : a;
        end else if (step) begin
            acc_q  <= nxt_hi_c;
            sh_q   <= nxt_lo_c;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU
// under a start/busy/done handshake, with all results and flags registered.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_multicycle_if.slave    bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    alu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    alu_op_t          op_e;
    logic             load, step, div_sel, wr;
    logic [WIDTH-1:0] nxt_lo_c, nxt_hi_c;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] res_d, hi_d;
    logic             c_d, v_d, dz_d;

    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, negative_q, carry_q, overflow_q, dz_q, busy_q, done_q;

    assign op_e = alu_op_t'(bus.op);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .div      (div_sel),
        .a        (bus.a),
        .b        (bus.b),
        .nxt_lo_c (nxt_lo_c),
        .nxt_hi_c (nxt_hi_c)
    );

    // Single-cycle result and arithmetic flags.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        add_w  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
        shamt  = bus.b[SHW-1:0];
        case (op_e)
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_NOR:  sc_res = ~(bus.a | bus.b);
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLTU: sc_res = WIDTH'(bus.a < bus.b);
            OP_SLT:  sc_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLL:  sc_res = bus.a << shamt;
            OP_SRL:  sc_res = bus.a >> shamt;
            OP_SRA:  sc_res = WIDTH'($signed(bus.a) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, iteration control and values to write on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        wr      = 1'b0;
        div_sel = 1'b0;
        res_d   = '0;
        hi_d    = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                div_sel = (op_e == OP_DIVU);
                if (bus.start) begin
                    if (is_iterative(bus.op) && !(op_e == OP_DIVU && bus.b == '0)) begin
                        load    = 1'b1;
                        cnt_d   = CW'(WIDTH);
                        state_d = (op_e == OP_MULU) ? MUL : DIV;
                    end else if (op_e == OP_DIVU) begin
                        wr    = 1'b1;
                        res_d = '1;
                        hi_d  = bus.a;
                        dz_d  = 1'b1;
                    end else begin
                        wr    = 1'b1;
                        res_d = sc_res;
                        c_d   = sc_c;
                        v_d   = sc_v;
                    end
                end
            end
            MUL, DIV: begin
                div_sel = (state_q == DIV);
                step    = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    wr      = 1'b1;
                    state_d = IDLE;
                    res_d   = nxt_lo_c;
                    hi_d    = nxt_hi_c;
                    v_d     = (state_q == MUL) && (nxt_hi_c != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= wr;
            if (wr) begin
                result_q    <= res_d;
                result_hi_q <= hi_d;
                zero_q      <= (res_d == '0);
                negative_q  <= res_d[WIDTH-1];
                carry_q     <= c_d;
                overflow_q  <= v_d;
                dz_q        <= dz_d;
            end
        end
    end

    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.zero        = zero_q;
    assign bus.negative    = negative_q;
    assign bus.carry       = carry_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = dz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
